// File: rtl/mult_tiled_seq.sv
// Sequential WIDTH x WIDTH multiplier that reuses a single exact 8x8 tile over N*N cycles.
// Define MULT_SIGNED_EN to take two's-complement operands; the default build is unsigned only.

module mult_tile8 (
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    output logic [15:0] prod
);
    assign prod = x * y;
endmodule

module mult_tiled_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
);
    localparam int TILE_W = 8;
    localparam int N      = WIDTH / TILE_W;
    localparam int PW     = 2 * WIDTH;
    localparam int IW     = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
`ifdef MULT_SIGNED_EN
        , S_NEG = 2'd3
`endif
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  a_op_q, b_op_q;
    logic [PW-1:0]     acc_q;
    logic [PW-1:0]     acc_d;
    logic [IW-1:0]     i_q, j_q;
    logic              in_ready_q, out_valid_q, busy_q;
    logic [TILE_W-1:0] a_slice, b_slice;
    logic [15:0]       tile;
    logic              last_i, last_j;
`ifdef MULT_SIGNED_EN
    logic              neg_q;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        // The most negative value maps onto 2^(WIDTH-1), which still fits unsigned.
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction
`endif

    mult_tile8 u_tile (
        .x    (a_slice),
        .y    (b_slice),
        .prod (tile)
    );

    // NOTE: every signal driven here gets a value on every path first, so no latch is inferred.
    always_comb begin
        a_slice = a_op_q[TILE_W*i_q +: TILE_W];
        b_slice = b_op_q[TILE_W*j_q +: TILE_W];
        acc_d   = acc_q + (PW'(tile) << (TILE_W * (int'(i_q) + int'(j_q))));
        last_i  = (i_q == IW'(N - 1));
        last_j  = (j_q == IW'(N - 1));
    end

    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_op_q      <= '0;
            b_op_q      <= '0;
            acc_q       <= '0;
            i_q         <= '0;
            j_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MULT_SIGNED_EN
            neg_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
`ifdef MULT_SIGNED_EN
                        a_op_q <= mag(a);
                        b_op_q <= mag(b);
                        neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
`else
                        a_op_q <= a;
                        b_op_q <= b;
`endif
                        acc_q      <= '0;
                        i_q        <= '0;
                        j_q        <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    if (last_j) begin
                        j_q <= '0;
                        if (last_i) begin
                            i_q <= '0;
`ifdef MULT_SIGNED_EN
                            state_q <= S_NEG;
`else
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
`endif
                        end else begin
                            i_q <= i_q + 1'b1;
                        end
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
`ifdef MULT_SIGNED_EN
                S_NEG: begin
                    acc_q       <= neg_q ? -acc_q : acc_q;
                    state_q     <= S_DONE;
                    out_valid_q <= 1'b1;
                end
`endif
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign p         = acc_q;

endmodule
